// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: widths, writeback result select and load funct3 codes.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ADDR = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load extractor: picks byte/half/word from an aligned memory word and extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            illegal
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{offset, 3'b000} +: 8];
  assign half_v = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data       = {{(XLEN-16){half_v[15]}}, half_v};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_v};
        misaligned = offset[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (offset != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, result select, register-file write port and retire counter.
module writeback_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            wb_stall,
  input  logic            wb_flush,
  input  logic            mem_reg_write,
  input  logic [ADDR-1:0] mem_rd_addr,
  input  logic [1:0]      mem_wb_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [XLEN-1:0] mem_pc_plus4,
  output logic            write_en,
  output logic [ADDR-1:0] rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            fwd_valid,
  output logic            load_fault,
  output logic [63:0]     instret
);
  // Handshake: a transfer happens on a rising edge where mem_valid && mem_ready,
  // unless wb_flush is high that cycle; every other cycle loads a bubble (no hold).
  logic            accept;
  logic [XLEN-1:0] load_value;
  logic            misaligned;
  logic            illegal;
  logic            fault;
  logic [XLEN-1:0] result;

  logic            we_q;
  logic            fault_q;
  logic [ADDR-1:0] rd_addr_q;
  logic [XLEN-1:0] rd_data_q;
  logic [63:0]     instret_q;

  assign mem_ready = !wb_stall;
  assign accept    = mem_valid && mem_ready && !wb_flush;

  load_align u_load_align (
    .word       (mem_load_data),
    .offset     (mem_alu_result[1:0]),
    .funct3     (mem_funct3),
    .data       (load_value),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign fault = (mem_wb_sel == WB_MEM) && (misaligned || illegal);

  always_comb begin
    result = mem_alu_result;
    case (mem_wb_sel)
      WB_MEM:  result = load_value;
      WB_PC4:  result = mem_pc_plus4;
      default: result = mem_alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      instret_q <= '0;
    end else if (accept) begin
      we_q      <= mem_reg_write && (mem_rd_addr != '0) && !fault;
      fault_q   <= fault;
      rd_addr_q <= mem_rd_addr;
      rd_data_q <= result;
      if (!fault) instret_q <= instret_q + 64'd1;
    end else begin
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end
  end

  assign write_en   = we_q;
  assign fwd_valid  = we_q;
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign load_fault = fault_q;
  assign instret    = instret_q;
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage RISC-V pipeline. Accepts completed instructions from the memory stage over a valid/ready handshake and registers them in the MEM/WB pipeline register. It selects and aligns the result (ALU, load data or PC+4) and drives the register file write port (write_en, rd_addr, rd_data) one cycle later. It also exports the in-flight write for forwarding, flags load-alignment faults, and maintains a 64-bit retired-instruction counter.

## Interface
Parameters (XLEN and ADDR come from riscv_pkg):
- XLEN, 32, register/data width
- ADDR, 5, register address width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  memory stage presents an instruction
- mem_ready  out  1  stage accepts this cycle; equals !wb_stall
- wb_stall  in  1  hazard-unit hold; blocks acceptance
- wb_flush  in  1  discard the instruction offered this cycle
- mem_reg_write  in  1  instruction writes rd
- mem_rd_addr  in  ADDR  destination register
- mem_wb_sel  in  2  result select, wb_sel_e
- mem_funct3  in  3  load size/sign (used when wb_sel = WB_MEM)
- mem_alu_result  in  XLEN  ALU result; also the load address ([1:0] is the byte offset)
- mem_load_data  in  XLEN  raw aligned 32-bit word read from data memory
- mem_pc_plus4  in  XLEN  link value
- write_en  out  1  register file write strobe
- rd_addr  out  ADDR  register file write address
- rd_data  out  XLEN  register file write data
- fwd_valid  out  1  equals write_en; forwarding-unit qualifier
- load_fault  out  1  one-cycle pulse: misaligned or illegal-funct3 load retired
- instret  out  64  count of retired, non-faulting instructions

## Operation
- Accept when mem_valid && mem_ready && !wb_flush. Otherwise the MEM/WB register loads a bubble.
- Holding a value is never done. A stalled cycle therefore produces write_en = 0 in the following cycle.
- Result select:
  - WB_ALU (2'b00): mem_alu_result
  - WB_MEM (2'b01): aligned load
  - WB_PC4 (2'b10): mem_pc_plus4
  - 2'b11: treated as WB_ALU
- Load alignment, with off = mem_alu_result[1:0]:
  - LB (000) / LBU (100): byte at off, sign- or zero-extended
  - LH (001) / LHU (101): half at off[1], sign- or zero-extended; off[0] = 1 is misaligned
  - LW (010): whole word; off != 0 is misaligned
  - funct3 011, 110, 111: illegal
- A fault on a WB_MEM instruction:
  - suppresses write_en
  - pulses load_fault for one cycle
  - does not increment instret
  - non-load instructions never fault
- write_en = captured valid && reg_write && rd_addr != 0 && !fault. Writes to x0 are always suppressed.
- instret increments by 1 in the cycle after each non-faulting acceptance, including rd = x0 and reg_write = 0 instructions. It wraps from 2^64-1 to 0.

## Timing
- Reset values: write_en 0, rd_addr 0, rd_data 0, fwd_valid 0, load_fault 0, instret 0. mem_ready follows wb_stall combinationally.
- Latency: an instruction accepted at edge N drives write_en/rd_addr/rd_data during cycle N..N+1. The register file commits at edge N+1.
- Throughput: one instruction per cycle, with no bubbles when wb_stall = 0.
- Simultaneous wb_flush and mem_valid: flush wins; a bubble is inserted.
- Simultaneous wb_stall and wb_flush: a bubble is inserted.
- The instruction already in MEM/WB is never cancelled by flush or stall.
- Reset mid-operation clears the MEM/WB register and instret immediately (asynchronous). The pending write is lost and no write_en is emitted.

## Structure
- riscv_pkg additions:
  - wb_sel_e enum {WB_ALU, WB_MEM, WB_PC4}
  - load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
- Sub-module load_align: combinational.
  - Inputs: word, offset, funct3.
  - Outputs: data, misaligned, illegal.
- writeback_stage instantiates load_align and holds the MEM/WB register and instret.
- Drives the writeback modport of register_file_if via the flat ports above.

## Test plan
- ALU write: rd = 5, WB_ALU, alu_result = 0xDEADBEEF accepted at edge N -> write_en = 1, rd_addr = 5, rd_data = 0xDEADBEEF for exactly one cycle; instret = 1.
- Loads on word 0x80F0_7F01: LB off = 3 -> 0xFFFFFF80; LBU off = 1 -> 0x0000007F; LH off = 2 -> 0xFFFF80F0; LHU off = 0 -> 0x00007F01.
- Faults: LW off = 2 and LH off = 1 -> write_en = 0, load_fault pulse, instret unchanged. funct3 = 3'b110 gives the same result.
- x0 and link: rd = 0 with reg_write = 1 -> write_en = 0 and instret increments. JAL rd = 1, pc_plus4 = 0x104 -> rd_data = 0x104.
- Stall/flush: back-to-back stream, then wb_stall for 2 cycles -> mem_ready = 0 and write_en = 0 for 2 cycles with no duplicate writes. mem_valid with wb_flush -> no write.
- Reset: assert rst mid-stream with write_en = 1 -> all outputs 0 asynchronously and instret = 0. instret preloaded to 2^64-1 via force and then a retire -> wraps to 0.
